// File: rtl/onehot_convergence_monitor.sv
// Convergence monitor for an iterative datapath state vector. Declares the
// vector converged once it is one-hot with the same hot index for
// STABLE_CYCLES consecutive valid samples. Gives up after MAX_ITER samples.
module onehot_convergence_monitor #(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = 3,
    parameter int unsigned MAX_ITER      = 8,
    parameter int unsigned IDXW          = $clog2(WIDTH),
    parameter int unsigned CNTW          = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [WIDTH-1:0] vec,
    output logic             finished,
    output logic             done_pulse,
    output logic             timeout,
    output logic [IDXW-1:0]  hot_idx,
    output logic [CNTW-1:0]  iter_count,
    output logic             vec_zero,
    output logic             vec_multi
);

    localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [WIDTH-1:0] VecOne    = WIDTH'(1);
    localparam logic [CNTW-1:0]  IterMax   = CNTW'(MAX_ITER);
    localparam logic [SW-1:0]    StableMax = SW'(STABLE_CYCLES);

    typedef enum logic [2:0] {StIdle, StRun, StConfirm, StDone, StTimeout} state_e;

    state_e          state_q, state_d;
    logic            finished_q, finished_d;
    logic            done_pulse_q, done_pulse_d;
    logic            timeout_q, timeout_d;
    logic [IDXW-1:0] hot_idx_q, hot_idx_d;
    logic [CNTW-1:0] iter_q, iter_d;
    logic [SW-1:0]   stable_q, stable_d;
    logic            zero_q, zero_d;
    logic            multi_q, multi_d;

    logic            is_zero, is_multi, is_onehot;
    logic [IDXW-1:0] vec_idx;

    // Classify the sample without a popcount: v & (v-1) clears the lowest set bit.
    always_comb begin
        is_zero   = ~|vec;
        is_multi  = |(vec & (vec - VecOne));
        is_onehot = ~is_zero & ~is_multi;
        vec_idx   = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (vec[i]) vec_idx = vec_idx | IDXW'(i);
        end
    end

    // Next-state and output register inputs.
    always_comb begin
        logic [CNTW-1:0] iter_inc;
        logic            converged;

        state_d      = state_q;
        finished_d   = finished_q;
        done_pulse_d = 1'b0;
        timeout_d    = timeout_q;
        hot_idx_d    = hot_idx_q;
        iter_d       = iter_q;
        stable_d     = stable_q;
        zero_d       = zero_q;
        multi_d      = multi_q;
        iter_inc     = (iter_q < IterMax) ? iter_q + CNTW'(1) : iter_q;
        converged    = 1'b0;

        if (start) begin
            state_d    = StRun;
            finished_d = 1'b0;
            timeout_d  = 1'b0;
            hot_idx_d  = '0;
            iter_d     = '0;
            stable_d   = '0;
            zero_d     = 1'b0;
            multi_d    = 1'b0;
        end else if (vec_valid && (state_q == StRun || state_q == StConfirm)) begin
            iter_d  = iter_inc;
            zero_d  = is_zero;
            multi_d = is_multi;
            if (!is_onehot) begin
                stable_d = '0;
                state_d  = StRun;
            end else if (state_q == StConfirm && vec_idx == hot_idx_q) begin
                stable_d  = stable_q + SW'(1);
                converged = (stable_d == StableMax);
                state_d   = StConfirm;
            end else begin
                hot_idx_d = vec_idx;
                stable_d  = SW'(1);
                converged = (StableMax == SW'(1));
                state_d   = StConfirm;
            end
            // Completion on the final permitted sample beats the timeout.
            if (converged) begin
                state_d      = StDone;
                finished_d   = 1'b1;
                done_pulse_d = 1'b1;
            end else if (iter_inc == IterMax) begin
                state_d   = StTimeout;
                timeout_d = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            finished_q   <= 1'b0;
            done_pulse_q <= 1'b0;
            timeout_q    <= 1'b0;
            hot_idx_q    <= '0;
            iter_q       <= '0;
            stable_q     <= '0;
            zero_q       <= 1'b0;
            multi_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            finished_q   <= finished_d;
            done_pulse_q <= done_pulse_d;
            timeout_q    <= timeout_d;
            hot_idx_q    <= hot_idx_d;
            iter_q       <= iter_d;
            stable_q     <= stable_d;
            zero_q       <= zero_d;
            multi_q      <= multi_d;
        end
    end

    assign finished   = finished_q;
    assign done_pulse = done_pulse_q;
    assign timeout    = timeout_q;
    assign hot_idx    = hot_idx_q;
    assign iter_count = iter_q;
    assign vec_zero   = zero_q;
    assign vec_multi  = multi_q;

endmodule

// File: tb/tb_onehot_convergence_monitor.sv
// Directed bench for onehot_convergence_monitor at WIDTH=4, STABLE_CYCLES=3, MAX_ITER=8.
module tb_onehot_convergence_monitor;

    logic       clk = 1'b0;
    logic       rst, start, vec_valid;
    logic [3:0] vec;
    logic       finished, done_pulse, timeout, vec_zero, vec_multi;
    logic [1:0] hot_idx;
    logic [3:0] iter_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    onehot_convergence_monitor #(
        .WIDTH(4),
        .STABLE_CYCLES(3),
        .MAX_ITER(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .vec_valid(vec_valid),
        .vec(vec),
        .finished(finished),
        .done_pulse(done_pulse),
        .timeout(timeout),
        .hot_idx(hot_idx),
        .iter_count(iter_count),
        .vec_zero(vec_zero),
        .vec_multi(vec_multi)
    );

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input logic [3:0] v);
        vec_valid = 1'b1;
        vec       = v;
        step();
        vec_valid = 1'b0;
        vec       = 4'b0000;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_all(input string tag, input int unsigned fin, input int unsigned dp,
                             input int unsigned to, input int unsigned hi, input int unsigned ic,
                             input int unsigned z, input int unsigned m);
        check_eq({tag, ".finished"}, finished, fin);
        check_eq({tag, ".done_pulse"}, done_pulse, dp);
        check_eq({tag, ".timeout"}, timeout, to);
        check_eq({tag, ".hot_idx"}, hot_idx, hi);
        check_eq({tag, ".iter_count"}, iter_count, ic);
        check_eq({tag, ".vec_zero"}, vec_zero, z);
        check_eq({tag, ".vec_multi"}, vec_multi, m);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec = 4'b0000;
        step();
        step();
        rst = 1'b0;
        check_all("reset", 0, 0, 0, 0, 0, 0, 0);

        // IDLE ignores samples.
        sample(4'b0100);
        check_all("idle_ignore", 0, 0, 0, 0, 0, 0, 0);

        // 1: three identical one-hot samples converge.
        pulse_start();
        sample(4'b0100);
        sample(4'b0100);
        check_all("t1_s2", 0, 0, 0, 2, 2, 0, 0);
        sample(4'b0100);
        check_all("t1_done", 1, 1, 0, 2, 3, 0, 0);
        step();
        check_eq("t1_pulse_once", done_pulse, 0);
        check_eq("t1_sticky", finished, 1);
        sample(4'b0001);
        check_all("t1_frozen", 1, 0, 0, 2, 3, 0, 0);

        // 2: index change restarts the stable count.
        pulse_start();
        check_all("t2_start", 0, 0, 0, 0, 0, 0, 0);
        sample(4'b0100);
        sample(4'b0100);
        sample(4'b0010);
        check_all("t2_s3", 0, 0, 0, 1, 3, 0, 0);
        sample(4'b0010);
        check_eq("t2_s4_fin", finished, 0);
        sample(4'b0010);
        check_all("t2_done", 1, 1, 0, 1, 5, 0, 0);

        // 3: zero/multi status, fallback to RUN, completion on the MAX_ITER-th sample.
        pulse_start();
        sample(4'b0000);
        check_all("t3_s1", 0, 0, 0, 0, 1, 1, 0);
        sample(4'b1010);
        check_all("t3_s2", 0, 0, 0, 0, 2, 0, 1);
        sample(4'b1000);
        check_all("t3_s3", 0, 0, 0, 3, 3, 0, 0);
        sample(4'b1000);
        sample(4'b0110);
        check_all("t3_s5", 0, 0, 0, 3, 5, 0, 1);
        sample(4'b1000);
        sample(4'b1000);
        check_all("t3_s7", 0, 0, 0, 3, 7, 0, 0);
        sample(4'b1000);
        check_all("t3_done", 1, 1, 0, 3, 8, 0, 0);

        // 4: never one-hot -> timeout after eight samples.
        pulse_start();
        for (int i = 0; i < 7; i++) sample(4'b0011);
        check_all("t4_s7", 0, 0, 0, 0, 7, 0, 1);
        sample(4'b0011);
        check_all("t4_timeout", 0, 0, 1, 0, 8, 0, 1);
        sample(4'b0001);
        check_all("t4_frozen", 0, 0, 1, 0, 8, 0, 1);
        pulse_start();
        check_all("t4_restart", 0, 0, 0, 0, 0, 0, 0);

        // 5: gaps hold state; rst beats start and vec_valid.
        sample(4'b0001);
        step();
        step();
        check_eq("t5_gap_hold", iter_count, 1);
        sample(4'b0001);
        check_all("t5_s2", 0, 0, 0, 0, 2, 0, 0);
        rst = 1'b1; start = 1'b1; vec_valid = 1'b1; vec = 4'b0001;
        step();
        rst = 1'b0; start = 1'b0; vec_valid = 1'b0;
        check_all("t5_reset", 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) sample(4'b0001);
        check_all("t5_idle", 0, 0, 0, 0, 0, 0, 0);

        // 6: start in DONE wins over a concurrent sample.
        pulse_start();
        for (int i = 0; i < 3; i++) sample(4'b0001);
        check_eq("t6_pre_done", finished, 1);
        start = 1'b1; vec_valid = 1'b1; vec = 4'b0001;
        step();
        start = 1'b0; vec_valid = 1'b0;
        check_all("t6_restart", 0, 0, 0, 0, 0, 0, 0);
        sample(4'b0001);
        check_eq("t6_run_iter", iter_count, 1);
        sample(4'b0001);
        sample(4'b0001);
        check_all("t6_done", 1, 1, 0, 0, 3, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
